cmp_sequencer: RTL and testbench

Shared multi-word magnitude-compare engine. Accepts compare requests from NREQ requesters, arbitrates round-robin, and feeds one combinational `comparatortree` instance. The instance is WIDTH bits wide and is time-multiplexed over NWORDS chunks, most significant chunk first, with early termination on the first unequal chunk. Sits between the integer/FP compare issue ports and the shared comparator datapath, and returns EQ/LT flags with the requester ID over a valid/ready response channel.

---
 rtl/cmp_sequencer.sv | 153 +++++++++++++++
 tb/tb_cmp_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cmp_sequencer.sv
// cmp_sequencer: round-robin shared multi-word magnitude comparator.
// One WIDTH-bit comparatortree is walked over NWORDS chunks, MS chunk first,
// stopping at the first unequal chunk; result returned on a valid/ready port.

// comparatortree: single-chunk equality plus unsigned and signed less-than.
module comparatortree #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             eq,
   output logic             lt_u,
   output logic             lt_s
);

   // purely combinational chunk compare
   always_comb begin
      eq   = (a == b);
      lt_u = (a < b);
      lt_s = ($signed(a) < $signed(b));
   end

endmodule

module cmp_sequencer #(
   parameter  int WIDTH  = 64,
   parameter  int NWORDS = 2,
   parameter  int NREQ   = 2,
   localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NREQ-1:0]               req_valid,
   output logic [NREQ-1:0]               req_ready,
   input  logic [NREQ-1:0]               req_signed,
   input  logic [NREQ*NWORDS*WIDTH-1:0]  req_a,
   input  logic [NREQ*NWORDS*WIDTH-1:0]  req_b,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [IDW-1:0]                rsp_id,
   output logic                          rsp_eq,
   output logic                          rsp_lt
);

   localparam int OPW = NWORDS * WIDTH;
   localparam int KW  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

   typedef enum logic [1:0] {IDLE, COMPARE, RESP} state_t;

   state_t            state_q, state_d;
   logic [IDW-1:0]    ptr_q;
   logic [KW-1:0]     k_q;
   logic [OPW-1:0]    a_q, b_q;
   logic              sgn_q;
   logic [IDW-1:0]    grant;
   logic              grant_vld;
   logic              accept;
   logic [WIDTH-1:0]  chunk_a, chunk_b;
   logic              chunk_eq, chunk_lt_u, chunk_lt_s, lt_sel;
   logic              top_chunk;
   int unsigned       idx;
   logic [IDW-1:0]    idx_n;

   // round-robin search from ptr upward with wrap; first valid requester wins
   always_comb begin
      grant     = '0;
      grant_vld = 1'b0;
      idx       = 0;
      idx_n     = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         idx   = (32'(ptr_q) + i) % NREQ;
         idx_n = IDW'(idx);
         if (!grant_vld && req_valid[idx_n]) begin
            grant     = idx_n;
            grant_vld = 1'b1;
         end
      end
   end

   assign accept = reset_n && (state_q == IDLE) && grant_vld;

   // chunk k of the latched operands feeds the shared comparator
   always_comb begin
      chunk_a   = a_q[k_q*WIDTH +: WIDTH];
      chunk_b   = b_q[k_q*WIDTH +: WIDTH];
      top_chunk = (k_q == KW'(NWORDS-1));
      lt_sel    = (sgn_q && top_chunk) ? chunk_lt_s : chunk_lt_u;
   end

   comparatortree #(.WIDTH(WIDTH)) u_cmp (
      .a    (chunk_a),
      .b    (chunk_b),
      .eq   (chunk_eq),
      .lt_u (chunk_lt_u),
      .lt_s (chunk_lt_s)
   );

   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grant_vld)                    state_d = COMPARE;
         COMPARE: if (!chunk_eq || (k_q == '0))     state_d = RESP;
         RESP:    if (rsp_ready)                    state_d = IDLE;
         default:                                   state_d = IDLE;
      endcase
   end

   // outputs: ready only for the winner in IDLE, valid while in RESP
   always_comb begin
      req_ready = '0;
      if (accept) req_ready[grant] = 1'b1;
      rsp_valid = (state_q == RESP);
   end

   // operand latch, chunk walk, pointer update and registered response fields
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q  <= '0;
         k_q    <= KW'(NWORDS-1);
         a_q    <= '0;
         b_q    <= '0;
         sgn_q  <= 1'b0;
         rsp_id <= '0;
         rsp_eq <= 1'b0;
         rsp_lt <= 1'b0;
      end else if (accept) begin
         a_q    <= req_a[grant*OPW +: OPW];
         b_q    <= req_b[grant*OPW +: OPW];
         sgn_q  <= req_signed[grant];
         rsp_id <= grant;
         k_q    <= KW'(NWORDS-1);
         ptr_q  <= (grant == IDW'(NREQ-1)) ? '0 : grant + 1'b1;
      end else if (state_q == COMPARE) begin
         if (!chunk_eq) begin
            rsp_eq <= 1'b0;
            rsp_lt <= lt_sel;
         end else if (k_q == '0) begin
            rsp_eq <= 1'b1;
            rsp_lt <= 1'b0;
         end else begin
            k_q <= k_q - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cmp_sequencer.sv
// tb_cmp_sequencer: directed vectors with hand-computed results for
// cmp_sequencer at WIDTH=64, NWORDS=2, NREQ=2.
module tb_cmp_sequencer;

   localparam int W   = 64;
   localparam int NW  = 2;
   localparam int NR  = 2;
   localparam int OPW = W * NW;

   logic              clk;
   logic              reset_n;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_ready;
   logic [NR-1:0]     req_signed;
   logic [NR*OPW-1:0] req_a;
   logic [NR*OPW-1:0] req_b;
   logic              rsp_valid;
   logic              rsp_ready;
   logic              rsp_id;
   logic              rsp_eq;
   logic              rsp_lt;

   int n_checks = 0;
   int n_fail   = 0;

   cmp_sequencer #(.WIDTH(W), .NWORDS(NW), .NREQ(NR)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_signed (req_signed),
      .req_a      (req_a),
      .req_b      (req_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_eq     (rsp_eq),
      .rsp_lt     (rsp_lt)
   );

   // free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // wait (bounded) for rsp_valid; returns cycles since accept edge count start
   task automatic wait_rsp(input string tag, inout int n);
      while (!rsp_valid && n < 20) begin
         check({tag, "_busy_ready"}, req_ready, 0);
         step();
         n++;
      end
      if (!rsp_valid) check({tag, "_timeout"}, 0, 1);
   endtask

   task automatic set_op(input int id, input logic sgn, input logic [127:0] a, input logic [127:0] b);
      req_signed[id]        = sgn;
      req_a[id*OPW +: OPW]  = a;
      req_b[id*OPW +: OPW]  = b;
   endtask

   // single request: check grant, latency (posedges from C0 to first rsp_valid), result
   task automatic run_req(input string tag, input int id, input logic sgn,
                          input logic [127:0] a, input logic [127:0] b,
                          input logic eeq, input logic elt, input int elat);
      int n;
      set_op(id, sgn, a, b);
      req_valid     = '0;
      req_valid[id] = 1'b1;
      #1;
      check({tag, "_ready"}, req_ready, 128'(1) << id);
      step();
      req_valid = '0;
      n = 1;
      wait_rsp(tag, n);
      check({tag, "_lat"}, n, elat);
      check({tag, "_id"},  rsp_id, id);
      check({tag, "_eq"},  rsp_eq, eeq);
      check({tag, "_lt"},  rsp_lt, elt);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      check({tag, "_done"}, rsp_valid, 0);
   endtask

   initial begin
      int n;
      int eg;
      reset_n    = 1'b0;
      req_valid  = 2'b11;
      req_signed = '0;
      req_a      = '0;
      req_b      = '0;
      rsp_ready  = 1'b0;
      #2;
      check("rst_ready", req_ready, 0);
      check("rst_valid", rsp_valid, 0);
      check("rst_id",    rsp_id, 0);
      check("rst_eq",    rsp_eq, 0);
      check("rst_lt",    rsp_lt, 0);
      step();
      step();
      req_valid = '0;
      reset_n   = 1'b1;
      step();

      run_req("t1_u_lt",    0, 1'b0, {64'h1, 64'h0}, {64'h2, 64'h0}, 1'b0, 1'b1, 2);
      run_req("t2_u_gt",    1, 1'b0, {64'h5, 64'hFFFF_FFFF_FFFF_FFFF}, {64'h5, 64'h0}, 1'b0, 1'b0, 3);
      run_req("t3_eq",      0, 1'b0, {64'hDEAD, 64'hBEEF}, {64'hDEAD, 64'hBEEF}, 1'b1, 1'b0, 3);
      run_req("t4_s_neg",   0, 1'b1, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0}, {64'h0, 64'h1}, 1'b0, 1'b1, 2);
      run_req("t4_u_big",   0, 1'b0, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0}, {64'h0, 64'h1}, 1'b0, 1'b0, 2);
      run_req("t4_s_lo_gt", 0, 1'b1, {64'h0, 64'h8000_0000_0000_0000}, {64'h0, 64'h1}, 1'b0, 1'b0, 3);
      run_req("t4_s_lo_lt", 1, 1'b1, {64'h0, 64'h1}, {64'h0, 64'h8000_0000_0000_0000}, 1'b0, 1'b1, 3);

      // both requesters held valid: grants alternate starting from req0 (ptr=0 here)
      set_op(0, 1'b0, {64'h1, 64'h0}, {64'h2, 64'h0});
      set_op(1, 1'b0, {64'h3, 64'h1}, {64'h3, 64'h0});
      req_valid = 2'b11;
      #1;
      for (int it = 0; it < 4; it++) begin
         eg = it % 2;
         check("arb_ready", req_ready, 128'(1) << eg);
         step();
         n = 1;
         wait_rsp("arb", n);
         check("arb_lat", n, (eg == 1) ? 3 : 2);
         check("arb_id",  rsp_id, eg);
         check("arb_eq",  rsp_eq, 0);
         check("arb_lt",  rsp_lt, (eg == 1) ? 0 : 1);
         if (it == 0) begin
            for (int c = 0; c < 5; c++) begin
               step();
               check("bp_valid", rsp_valid, 1);
               check("bp_id",    rsp_id, 0);
               check("bp_eq",    rsp_eq, 0);
               check("bp_lt",    rsp_lt, 1);
               check("bp_ready", req_ready, 0);
            end
         end
         rsp_ready = 1'b1;
         step();
         rsp_ready = 1'b0;
      end
      req_valid = '0;
      step();

      // leave rsp_eq=1 so the reset clearing it is observable
      run_req("pre_rst_eq", 1, 1'b0, {64'h9, 64'h9}, {64'h9, 64'h9}, 1'b1, 1'b0, 3);

      // reset during COMPARE of an equal-hi request from req0 (ptr moves to 1)
      set_op(0, 1'b0, {64'h7, 64'h0}, {64'h7, 64'h5});
      req_valid = 2'b01;
      #1;
      check("rst6_accept", req_ready, 2'b01);
      step();
      reset_n   = 1'b0;
      req_valid = 2'b11;
      #1;
      check("rst6_ready", req_ready, 0);
      check("rst6_valid", rsp_valid, 0);
      check("rst6_id",    rsp_id, 0);
      check("rst6_eq",    rsp_eq, 0);
      check("rst6_lt",    rsp_lt, 0);
      for (int c = 0; c < 3; c++) begin
         step();
         check("rst6_hold_valid", rsp_valid, 0);
         check("rst6_hold_ready", req_ready, 0);
      end
      reset_n = 1'b1;
      #1;
      check("rst6_first_grant", req_ready, 2'b01);
      check("rst6_no_rsp", rsp_valid, 0);
      step();
      req_valid = '0;
      n = 1;
      wait_rsp("rst6_post", n);
      check("rst6_post_lat", n, 3);
      check("rst6_post_id",  rsp_id, 0);
      check("rst6_post_eq",  rsp_eq, 0);
      check("rst6_post_lt",  rsp_lt, 1);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
